// File: rtl/bidi_mq_stream_engine.sv
// ---------------------------------------------------------------------------
// bidi_mq_stream_engine
//
// Moves 32-bit stream words between two streaming ports and a shared
// single-port ring SRAM. The lower half of the SRAM is the inbound ring,
// which the engine fills and the processor drains. The upper half is the
// outbound ring, which the processor fills and the engine drains. Only one
// SRAM access is made at a time. When both directions want the SRAM in the
// same cycle, the arbiter grants the direction that did not win last time.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   in_data/in_valid    inbound stream word and its valid flag
//   in_ready            inbound word taken this cycle
//   out_data/out_valid  outbound stream word, held until out_ready
//   out_ready           consumer takes the outbound word
//   mem_addr            ring SRAM word address
//   mem_write_en        SRAM write strobe
//   mem_read_en         SRAM read strobe
//   mem_write_data      SRAM write data
//   mem_read_data       SRAM read data, valid one cycle after mem_read_en
//   inbound_rd_ptr      processor-owned inbound read pointer (low PW bits)
//   inbound_wr_ptr      engine-owned inbound write pointer (zero-extended)
//   outbound_wr_ptr     processor-owned outbound write pointer (low PW bits)
//   outbound_rd_ptr     engine-owned outbound read pointer (zero-extended)
// ---------------------------------------------------------------------------
module bidi_mq_stream_engine #(
  parameter  int QUEUE_ADDR_BITS = 10,
  localparam int DATA_W          = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [QUEUE_ADDR_BITS-1:0] mem_addr,
  output logic                       mem_write_en,
  output logic                       mem_read_en,
  output logic [DATA_W-1:0]          mem_write_data,
  input  logic [DATA_W-1:0]          mem_read_data,
  input  logic [31:0]                inbound_rd_ptr,
  output logic [31:0]                inbound_wr_ptr,
  input  logic [31:0]                outbound_wr_ptr,
  output logic [31:0]                outbound_rd_ptr
);

  localparam int PW = QUEUE_ADDR_BITS - 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_CAP
  } state_t;

  localparam logic GRANT_IN  = 1'b0;
  localparam logic GRANT_OUT = 1'b1;

  state_t                     state_q, state_d;
  logic [PW-1:0]              in_wr_ptr_q, in_wr_ptr_d;
  logic [PW-1:0]              out_rd_ptr_q, out_rd_ptr_d;
  logic                       out_valid_q, out_valid_d;
  logic [DATA_W-1:0]          out_data_q, out_data_d;
  logic                       last_grant_q, last_grant_d;
  logic [QUEUE_ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic                       mem_write_en_q, mem_write_en_d;
  logic                       mem_read_en_q, mem_read_en_d;
  logic [DATA_W-1:0]          mem_write_data_q, mem_write_data_d;

  logic in_req;
  logic out_req;
  logic grant_in;
  logic grant_out;
  logic unused_ptr_bits;

  // Ring pointers are exactly PW bits wide, so the natural overflow of the
  // increment is the wrap from QSZ-1 back to 0.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return p + PW'(1);
  endfunction

  // Only the low PW bits of the processor pointers take part in ring indexing.
  assign unused_ptr_bits = ^{inbound_rd_ptr[31:PW], outbound_wr_ptr[31:PW]};

  // One slot is always left empty so that a full ring can be told apart
  // from an empty one.
  assign in_req  = in_valid && (ptr_inc(in_wr_ptr_q) != inbound_rd_ptr[PW-1:0]);
  assign out_req = !out_valid_q && (out_rd_ptr_q != outbound_wr_ptr[PW-1:0]);

  assign grant_in  = (state_q == ST_IDLE) && in_req &&
                     (!out_req || (last_grant_q == GRANT_OUT));
  assign grant_out = (state_q == ST_IDLE) && out_req &&
                     (!in_req || (last_grant_q == GRANT_IN));

  assign in_ready = grant_in && !rst;

  always_comb begin
    state_d          = state_q;
    in_wr_ptr_d      = in_wr_ptr_q;
    out_rd_ptr_d     = out_rd_ptr_q;
    out_valid_d      = out_valid_q;
    out_data_d       = out_data_q;
    last_grant_d     = last_grant_q;
    mem_addr_d       = mem_addr_q;
    mem_write_en_d   = 1'b0;
    mem_read_en_d    = 1'b0;
    mem_write_data_d = mem_write_data_q;

    // A consumer handshake retires the word held in the output register.
    if (out_valid_q && out_ready) begin
      out_valid_d  = 1'b0;
      out_rd_ptr_d = ptr_inc(out_rd_ptr_q);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (grant_in) begin
          state_d          = ST_WR;
          mem_write_en_d   = 1'b1;
          mem_addr_d       = {1'b0, in_wr_ptr_q};
          mem_write_data_d = in_data;
          last_grant_d     = GRANT_IN;
        end else if (grant_out) begin
          state_d       = ST_RD;
          mem_read_en_d = 1'b1;
          mem_addr_d    = {1'b1, out_rd_ptr_q};
          last_grant_d  = GRANT_OUT;
        end
      end
      ST_WR: begin
        // The write strobe is on the bus this cycle; publish the slot.
        in_wr_ptr_d = ptr_inc(in_wr_ptr_q);
        state_d     = ST_IDLE;
      end
      ST_RD: begin
        state_d = ST_CAP;
      end
      ST_CAP: begin
        // SRAM read data is valid in the cycle after the read strobe.
        out_data_d  = mem_read_data;
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      in_wr_ptr_q      <= '0;
      out_rd_ptr_q     <= '0;
      out_valid_q      <= 1'b0;
      out_data_q       <= '0;
      last_grant_q     <= GRANT_OUT;
      mem_addr_q       <= '0;
      mem_write_en_q   <= 1'b0;
      mem_read_en_q    <= 1'b0;
      mem_write_data_q <= '0;
    end else begin
      state_q          <= state_d;
      in_wr_ptr_q      <= in_wr_ptr_d;
      out_rd_ptr_q     <= out_rd_ptr_d;
      out_valid_q      <= out_valid_d;
      out_data_q       <= out_data_d;
      last_grant_q     <= last_grant_d;
      mem_addr_q       <= mem_addr_d;
      mem_write_en_q   <= mem_write_en_d;
      mem_read_en_q    <= mem_read_en_d;
      mem_write_data_q <= mem_write_data_d;
    end
  end

  assign out_data        = out_data_q;
  assign out_valid       = out_valid_q;
  assign mem_addr        = mem_addr_q;
  assign mem_write_en    = mem_write_en_q;
  assign mem_read_en     = mem_read_en_q;
  assign mem_write_data  = mem_write_data_q;
  assign inbound_wr_ptr  = {{(32-PW){1'b0}}, in_wr_ptr_q};
  assign outbound_rd_ptr = {{(32-PW){1'b0}}, out_rd_ptr_q};

endmodule

// File: tb/tb_bidi_mq_stream_engine.sv
// ---------------------------------------------------------------------------
// tb_bidi_mq_stream_engine
//
// Self-checking bench for bidi_mq_stream_engine with the default 1024-word
// ring (512 words per direction). A behavioural SRAM answers reads one
// cycle after the strobe. The processor side is modelled as two ring
// pointers. Directed steps cover reset, single transfers, output hold,
// full-ring back-pressure, arbitration order and reset during a read. A
// randomized phase then compares every SRAM access, pointer value and
// delivered word against a queue/array reference model.
// ---------------------------------------------------------------------------
module tb_bidi_mq_stream_engine;
  localparam int QAB = 10;
  localparam int QSZ = 512;

  logic           clk = 1'b0;
  logic           rst;
  logic [31:0]    in_data;
  logic           in_valid;
  logic           in_ready;
  logic [31:0]    out_data;
  logic           out_valid;
  logic           out_ready;
  logic [QAB-1:0] mem_addr;
  logic           mem_write_en;
  logic           mem_read_en;
  logic [31:0]    mem_write_data;
  logic [31:0]    mem_read_data;
  logic [31:0]    inbound_rd_ptr;
  logic [31:0]    inbound_wr_ptr;
  logic [31:0]    outbound_wr_ptr;
  logic [31:0]    outbound_rd_ptr;

  int n_tests  = 0;
  int n_fail   = 0;
  int both_cnt = 0;

  logic [31:0] ib_mem [0:QSZ-1];
  logic [31:0] ob_mem [0:QSZ-1];

  always #5 clk = ~clk;

  bidi_mq_stream_engine #(.QUEUE_ADDR_BITS(QAB)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .mem_addr       (mem_addr),
    .mem_write_en   (mem_write_en),
    .mem_read_en    (mem_read_en),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .inbound_rd_ptr (inbound_rd_ptr),
    .inbound_wr_ptr (inbound_wr_ptr),
    .outbound_wr_ptr(outbound_wr_ptr),
    .outbound_rd_ptr(outbound_rd_ptr)
  );

  // Ring SRAM: inbound half is written by the engine, outbound half is
  // preloaded by the bench and only read by the engine.
  always @(posedge clk) begin
    if (mem_write_en && !mem_addr[QAB-1]) ib_mem[mem_addr[QAB-2:0]] <= mem_write_data;
    if (mem_read_en) mem_read_data <= mem_addr[QAB-1] ? ob_mem[mem_addr[QAB-2:0]]
                                                      : ib_mem[mem_addr[QAB-2:0]];
    if (mem_write_en && mem_read_en) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference-model state for the randomized phase
  int          m_in_wr, m_in_rd, m_out_rd, m_out_wr;
  logic [31:0] exp_wq[$];
  logic [31:0] front;
  logic [31:0] prev_data;
  bit          hold_prev;
  bit          saw_in_wrap, saw_out_wrap;
  int          ev, wcnt, rcnt, hs, e_writes, e_extra;
  bit          got;
  logic [31:0] e_word;

  initial begin
    // ---------------- reset state ----------------
    rst = 1'b1; in_valid = 1'b1; in_data = 32'h1234_5678; out_ready = 1'b0;
    inbound_rd_ptr = 0; outbound_wr_ptr = 3;
    for (int i = 0; i < QSZ; i++) ob_mem[i] = $urandom();
    ob_mem[0] = 32'hDEAD_BEEF;
    repeat (3) tick();
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_wen", mem_write_en, 0);
    check("rst_ren", mem_read_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_write_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_wr_ptr", inbound_wr_ptr, 0);
    check("rst_out_rd_ptr", outbound_rd_ptr, 0);

    // ---------------- single inbound accept ----------------
    rst = 1'b0; in_valid = 1'b1; in_data = 32'hA5A5_0001; outbound_wr_ptr = 0;
    #1;
    check("b_in_ready", in_ready, 1);
    tick(); in_valid = 1'b0; #1;
    check("b_wen", mem_write_en, 1);
    check("b_ren", mem_read_en, 0);
    check("b_addr", mem_addr, 0);
    check("b_wdata", mem_write_data, 32'hA5A5_0001);
    check("b_wr_ptr_old", inbound_wr_ptr, 0);
    tick(); #1;
    check("b_wr_ptr", inbound_wr_ptr, 1);
    check("b_wen_clr", mem_write_en, 0);
    check("b_sram", ib_mem[0], 32'hA5A5_0001);

    // ---------------- single outbound read and hold ----------------
    outbound_wr_ptr = 1; out_ready = 1'b0;
    #1;
    check("c_in_ready", in_ready, 0);
    tick(); #1;
    check("c_ren", mem_read_en, 1);
    check("c_wen", mem_write_en, 0);
    check("c_raddr", mem_addr, QSZ);
    tick(); #1;
    check("c_cap_valid", out_valid, 0);
    check("c_ren_off", mem_read_en, 0);
    tick(); #1;
    check("c_valid", out_valid, 1);
    check("c_data", out_data, 32'hDEAD_BEEF);
    for (int i = 0; i < 10; i++) begin
      tick(); #1;
      check("c_hold_valid", out_valid, 1);
      check("c_hold_data", out_data, 32'hDEAD_BEEF);
      check("c_hold_noread", mem_read_en, 0);
    end
    check("c_rd_ptr_held", outbound_rd_ptr, 0);
    out_ready = 1'b1;
    tick(); out_ready = 1'b0; #1;
    check("c_valid_clr", out_valid, 0);
    check("c_rd_ptr", outbound_rd_ptr, 1);

    // ---------------- arbitration alternates, inbound first ----------------
    rst = 1'b1; in_valid = 1'b0; outbound_wr_ptr = 0; inbound_rd_ptr = 0;
    tick(); tick();
    rst = 1'b0; in_valid = 1'b1; in_data = $urandom(); outbound_wr_ptr = 4; out_ready = 1'b1;
    ev = 0; wcnt = 0; rcnt = 0; hs = 0;
    for (int c = 0; c < 80 && ev < 8; c++) begin
      #1;
      if (mem_write_en) begin
        check("d_order", 0, ev % 2);
        check("d_waddr", mem_addr, wcnt);
        wcnt++; ev++;
      end
      if (mem_read_en) begin
        check("d_order", 1, ev % 2);
        check("d_raddr", mem_addr, QSZ + rcnt);
        rcnt++; ev++;
      end
      if (out_valid && out_ready) begin
        check("d_odata", out_data, ob_mem[hs]);
        hs++;
      end
      tick();
      in_data = $urandom();
    end
    check("d_events", ev, 8);
    in_valid = 1'b0;
    repeat (6) tick();

    // ---------------- inbound full back-pressure ----------------
    rst = 1'b1; out_ready = 1'b0; outbound_wr_ptr = 0;
    tick(); tick();
    rst = 1'b0; inbound_rd_ptr = 5; in_valid = 1'b1; e_word = $urandom(); in_data = e_word;
    e_writes = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (mem_write_en) e_writes++;
      if (c >= 20) begin
        check("e_full_ready", in_ready, 0);
        check("e_full_wen", mem_write_en, 0);
      end
      tick();
    end
    check("e_writes", e_writes, 4);
    check("e_wr_ptr_full", inbound_wr_ptr, 4);
    inbound_rd_ptr = 6;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      #1;
      if (mem_write_en) begin
        got = 1'b1;
        check("e_refill_addr", mem_addr, 4);
        check("e_refill_data", mem_write_data, e_word);
      end
      tick();
    end
    check("e_refill_seen", got, 1);
    e_extra = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (mem_write_en) e_extra++;
      tick();
    end
    check("e_no_extra", e_extra, 0);
    check("e_wr_ptr", inbound_wr_ptr, 5);

    // ---------------- reset during a read ----------------
    rst = 1'b1; in_valid = 1'b0; inbound_rd_ptr = 0; outbound_wr_ptr = 0;
    tick(); tick();
    rst = 1'b0; outbound_wr_ptr = 1;
    tick(); #1;
    check("f_ren", mem_read_en, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; outbound_wr_ptr = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      check("f_no_valid", out_valid, 0);
      check("f_no_read", mem_read_en, 0);
      check("f_out_rd_ptr", outbound_rd_ptr, 0);
      check("f_in_wr_ptr", inbound_wr_ptr, 0);
      tick();
    end
    outbound_wr_ptr = 1;
    got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      #1;
      if (mem_read_en) check("f_raddr", mem_addr, QSZ);
      if (out_valid) begin
        got = 1'b1;
        check("f_data", out_data, ob_mem[0]);
      end
      tick();
    end
    check("f_valid_seen", got, 1);

    // ---------------- randomized traffic against the reference model -------
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; inbound_rd_ptr = 0; outbound_wr_ptr = 0;
    tick(); tick();
    rst = 1'b0;
    m_in_wr = 0; m_in_rd = 0; m_out_rd = 0; m_out_wr = 0;
    hold_prev = 1'b0; prev_data = '0; saw_in_wrap = 1'b0; saw_out_wrap = 1'b0;
    in_valid = 1'b1; in_data = $urandom(); out_ready = 1'b1;
    for (int c = 0; c < 8000; c++) begin
      #1;
      check("g_in_wr_ptr", inbound_wr_ptr, m_in_wr);
      check("g_out_rd_ptr", outbound_rd_ptr, m_out_rd);
      if (hold_prev) begin
        check("g_hold_valid", out_valid, 1);
        check("g_hold_data", out_data, prev_data);
      end
      if (in_ready) begin
        check("g_rdy_valid", in_valid, 1);
        check("g_rdy_not_full", ((m_in_wr + 1) % QSZ) != m_in_rd, 1);
        exp_wq.push_back(in_data);
      end
      if (mem_write_en) begin
        check("g_w_pending", exp_wq.size() > 0, 1);
        check("g_waddr", mem_addr, m_in_wr);
        if (exp_wq.size() > 0) begin
          front = exp_wq.pop_front();
          check("g_wdata", mem_write_data, front);
        end
        if (m_in_wr == QSZ - 1) saw_in_wrap = 1'b1;
        m_in_wr = (m_in_wr + 1) % QSZ;
      end
      if (mem_read_en) begin
        check("g_raddr", mem_addr, QSZ + m_out_rd);
        check("g_read_while_valid", out_valid, 0);
        if (m_out_rd == QSZ - 1) saw_out_wrap = 1'b1;
      end
      if (out_valid && out_ready) begin
        check("g_odata", out_data, ob_mem[m_out_rd]);
        m_out_rd = (m_out_rd + 1) % QSZ;
      end
      hold_prev = out_valid && !out_ready;
      prev_data = out_data;
      tick();
      in_valid  = ($urandom_range(0, 9) < 8);
      in_data   = $urandom();
      out_ready = ($urandom_range(0, 3) != 0);
      if ((m_in_rd != m_in_wr) && ($urandom_range(0, 1) == 1)) m_in_rd = (m_in_rd + 1) % QSZ;
      if ((((m_out_wr + 1) % QSZ) != m_out_rd) && ($urandom_range(0, 1) == 1))
        m_out_wr = (m_out_wr + 1) % QSZ;
      inbound_rd_ptr  = m_in_rd;
      outbound_wr_ptr = m_out_wr;
    end
    check("g_in_wrap_seen", saw_in_wrap, 1);
    check("g_out_wrap_seen", saw_out_wrap, 1);
    check("both_strobes", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
